// File: rtl/alu_multicycle.sv
// alu_multicycle: valid/ready ALU with single-cycle ops and iterative MUL/DIVU/REMU
module alu_multicycle #(
    parameter int WIDTH  = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [3:0]       aluControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluResult,
    output logic             zero,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT state, nextState;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] regA, regB, acc;
    logic             opMul, opRem;
    logic             isMul, isDiv, isLong, lastStep;
    logic [WIDTH-1:0] quickResult;
    logic             quickIllegal;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   remShift;
    logic             ge;
    logic [WIDTH-1:0] mulAcc, divAcc, divQuo, longResult;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign shamt     = srcB[SHW-1:0];
    assign isMul     = aluControl == 4'b1010;
    assign isDiv     = DIV_EN && (aluControl == 4'b1011 || aluControl == 4'b1100);
    assign isLong    = isMul || isDiv;
    assign lastStep  = counter == CW'(1);

    always_comb begin
        quickResult  = '0;
        quickIllegal = aluControl > 4'd9 && !isLong;
        case (aluControl)
            4'd0: quickResult = srcA + srcB;
            4'd1: quickResult = srcA - srcB;
            4'd2: quickResult = srcA & srcB;
            4'd3: quickResult = srcA | srcB;
            4'd4: quickResult = srcA ^ srcB;
            4'd5: quickResult = srcA << shamt;
            4'd6: quickResult = srcA >> shamt;
            4'd7: quickResult = $signed(srcA) >>> shamt;
            4'd8: quickResult = {{(WIDTH-1){1'b0}}, $signed(srcA) < $signed(srcB)};
            4'd9: quickResult = {{(WIDTH-1){1'b0}}, srcA < srcB};
            default: quickResult = '0;
        endcase
    end

    // MUL: acc accumulates, regA is the shifting multiplicand, regB the shifting multiplier.
    // DIVU/REMU: acc is the partial remainder, regA the divisor, regB dividend bits becoming quotient.
    always_comb begin
        remShift   = {acc, regB[WIDTH-1]};
        ge         = remShift >= {1'b0, regA};
        divAcc     = ge ? remShift[WIDTH-1:0] - regA : remShift[WIDTH-1:0];
        divQuo     = {regB[WIDTH-2:0], ge};
        mulAcc     = acc + (regB[0] ? regA : '0);
        longResult = opMul ? mulAcc : (opRem ? divAcc : divQuo);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (in_valid) nextState = isLong ? BUSY : DONE;
            BUSY:    if (lastStep) nextState = DONE;
            DONE:    if (out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (flush) nextState = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter   <= '0;
            regA      <= '0;
            regB      <= '0;
            acc       <= '0;
            opMul     <= 1'b0;
            opRem     <= 1'b0;
            aluResult <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
        end else if (!flush) begin
            if (state == IDLE && in_valid) begin
                if (isLong) begin
                    counter <= CW'(WIDTH);
                    opMul   <= isMul;
                    opRem   <= aluControl == 4'b1100;
                    regA    <= isMul ? srcA : srcB;
                    regB    <= isMul ? srcB : srcA;
                    acc     <= '0;
                end else begin
                    aluResult <= quickResult;
                    zero      <= quickResult == '0;
                    illegal   <= quickIllegal;
                end
            end else if (state == BUSY) begin
                counter <= counter - CW'(1);
                acc     <= opMul ? mulAcc : divAcc;
                regA    <= opMul ? regA << 1 : regA;
                regB    <= opMul ? regB >> 1 : divQuo;
                if (lastStep) begin
                    aluResult <= longResult;
                    zero      <= longResult == '0;
                    illegal   <= 1'b0;
                end
            end
        end
    end
endmodule
